// File: rtl/dist_pkg.sv
// Shared definitions for the ultrasonic range-sensor front end.
//   DIST_W     : width of the distance result
//   DIST_NONE  : result code meaning "no valid reading"
//   DIST_SAT   : largest reportable distance (one below DIST_NONE)
//   dist_state_t : measurement FSM states
package dist_pkg;

    localparam int DIST_W = 16;
    localparam logic [DIST_W-1:0] DIST_NONE = 16'h7FFF;
    localparam logic [DIST_W-1:0] DIST_SAT  = 16'h7FFE;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        WAIT_PERIOD
    } dist_state_t;

    // Saturating increment: a good reading can never reach DIST_NONE.
    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        return (v >= DIST_SAT) ? DIST_SAT : v + 16'd1;
    endfunction

endpackage

// File: rtl/dist_sensor_if_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dist_sensor_if.sv
// Ultrasonic range-sensor front end. Fires a trigger pulse every
// PERIOD_CYCLES, times the synchronized echo pulse and converts its width
// to distance units (floor(high_cycles / CYC_PER_UNIT), saturating).
//   clk          : system clock
//   rstn         : asynchronous active-low reset
//   echo         : raw sensor echo, asynchronous to clk
//   trig         : registered sensor trigger
//   dist_v       : last distance; DIST_NONE when there is no valid reading
//   dist_valid   : one-cycle strobe, dist_v was just updated by a good reading
//   dist_timeout : one-cycle strobe, dist_v was just set to DIST_NONE
//   state_dbg    : current FSM state, for observation only
// Strobe semantics: dist_valid / dist_timeout are high in the same cycle in
// which dist_v first shows the new value; there is no back-pressure, the
// consumer must sample dist_v on the strobe or read the held value later.
module dist_sensor_if
    import dist_pkg::*;
#(
    parameter int TRIG_CYCLES    = 10,
    parameter int CYC_PER_UNIT   = 58,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int PERIOD_CYCLES  = 60000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] dist_v,
    output logic              dist_valid,
    output logic              dist_timeout,
    output dist_state_t       state_dbg
);

    localparam int PSC_W = (CYC_PER_UNIT > 1) ? $clog2(CYC_PER_UNIT) : 1;
    localparam int CNT_W = $clog2(PERIOD_CYCLES);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [PSC_W-1:0] PSC_LAST  = PSC_W'(CYC_PER_UNIT - 1);

    // The period must cover trigger, a full rise wait and a full echo.
    if (PERIOD_CYCLES <= TRIG_CYCLES + 2 * TIMEOUT_CYCLES + 4) begin : g_bad_period
        $error("dist_sensor_if: PERIOD_CYCLES too small for TRIG/TIMEOUT settings");
    end
    if (TRIG_CYCLES < 1 || CYC_PER_UNIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("dist_sensor_if: TRIG_CYCLES, CYC_PER_UNIT, TIMEOUT_CYCLES must be >= 1");
    end

    logic echo_s;

    sync2 u_echo_sync (
        .clk   (clk),
        .rst_n (rstn),
        .d     (echo),
        .q     (echo_s)
    );

    dist_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;    // cycles in TRIG / WAIT_RISE, high cycles in MEASURE
    logic [CNT_W-1:0]  per_q, per_d;    // cycles since the current trigger started
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [DIST_W-1:0] unit_q, unit_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              trig_q, trig_d;
    logic              valid_q, valid_d;
    logic              tmo_q, tmo_d;

    // Prescaler / unit counter after accounting for one more echo-high cycle.
    logic [PSC_W-1:0]  psc_next;
    logic [DIST_W-1:0] unit_next;

    always_comb begin
        if (psc_q == PSC_LAST) begin
            psc_next  = '0;
            unit_next = sat_inc(unit_q);
        end else begin
            psc_next  = psc_q + PSC_W'(1);
            unit_next = unit_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q + CNT_W'(1);
        psc_d   = psc_q;
        unit_d  = unit_q;
        dist_d  = dist_q;
        trig_d  = trig_q;
        valid_d = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = TRIG;
                trig_d  = 1'b1;
                cnt_d   = '0;
                per_d   = '0;
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                    psc_d   = '0;
                    unit_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_RISE: begin
                // The cycle in which the rise is seen is the first high cycle.
                if (echo_s) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                    psc_d   = psc_next;
                    unit_d  = unit_next;
                end else if (cnt_q == TO_LAST) begin
                    state_d = WAIT_PERIOD;
                    dist_d  = DIST_NONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_d = WAIT_PERIOD;
                    dist_d  = unit_q;
                    valid_d = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    state_d = WAIT_PERIOD;
                    dist_d  = DIST_NONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    psc_d  = psc_next;
                    unit_d = unit_next;
                end
            end
            WAIT_PERIOD: begin
                if (per_q == PER_LAST) begin
                    state_d = TRIG;
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                trig_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            psc_q   <= '0;
            unit_q  <= '0;
            dist_q  <= DIST_NONE;
            trig_q  <= 1'b0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            psc_q   <= psc_d;
            unit_q  <= unit_d;
            dist_q  <= dist_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
        end
    end

    assign trig         = trig_q;
    assign dist_v       = dist_q;
    assign dist_valid   = valid_q;
    assign dist_timeout = tmo_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_dist_sensor_if.sv
// Testbench for dist_sensor_if. Edge k is the k-th rising clk edge after
// rstn release; raw echo for edge k is driven in the preceding low phase.
// The expected model works per trigger period: it locates the echo rise
// the FSM sees inside the rise window, measures the run length of the
// synchronized echo and derives the event edge and result arithmetically.
module tb_dist_sensor_if;
    import dist_pkg::*;

    localparam int A_TRIG = 4, A_CPU = 10, A_TO = 200,   A_PER = 500;
    localparam int B_TRIG = 4, B_CPU = 1,  B_TO = 40000, B_PER = 90000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        echo_a = 1'b0, echo_b = 1'b0;
    logic        trig_a, trig_b, valid_a, valid_b, tmo_a, tmo_b;
    logic [15:0] dist_a, dist_b;
    dist_state_t st_a, st_b;

    always #5 clk = ~clk;

    dist_sensor_if #(
        .TRIG_CYCLES(A_TRIG), .CYC_PER_UNIT(A_CPU),
        .TIMEOUT_CYCLES(A_TO), .PERIOD_CYCLES(A_PER)
    ) dut (
        .clk(clk), .rstn(rstn), .echo(echo_a), .trig(trig_a), .dist_v(dist_a),
        .dist_valid(valid_a), .dist_timeout(tmo_a), .state_dbg(st_a)
    );

    dist_sensor_if #(
        .TRIG_CYCLES(B_TRIG), .CYC_PER_UNIT(B_CPU),
        .TIMEOUT_CYCLES(B_TO), .PERIOD_CYCLES(B_PER)
    ) dut_sat (
        .clk(clk), .rstn(rstn), .echo(echo_b), .trig(trig_b), .dist_v(dist_b),
        .dist_valid(valid_b), .dist_timeout(tmo_b), .state_dbg(st_b)
    );

    int n_pass = 0;
    int n_total = 0;

    // Stimulus: raw echo high on edges [ev_rise, ev_rise + ev_len)
    int ev_rise[$];
    int ev_len[$];

    // Model: result events and trigger starts
    int          m_edge[$];
    logic [15:0] m_val[$];
    logic        m_is_to[$];
    int          trig_starts[$];
    int          sel;
    int          p_trig, p_cpu, p_to, p_per;

    // Observations from the DUT
    int          obs_valid, obs_to, obs_valid_edge, obs_to_edge;
    int          obs_trig_q[$];
    logic [15:0] obs_dist;
    logic        prev_trig;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_cyc(input string nm, input int k, input logic [18:0] act,
                             input logic [18:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s edge %0d {trig,valid,timeout,dist}: got %h expected %h",
                      nm, k, act, exp);
    endtask

    function automatic logic echo_raw(input int k);
        foreach (ev_rise[i])
            if (k >= ev_rise[i] && k < ev_rise[i] + ev_len[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Value the FSM sees at edge k after the two-flop delay.
    function automatic logic echo_seen(input int k);
        if (k < 3) return 1'b0;
        return echo_raw(k - 2);
    endfunction

    function automatic logic [18:0] dut_outs();
        if (sel != 0) return {trig_b, valid_b, tmo_b, dist_b};
        return {trig_a, valid_a, tmo_a, dist_a};
    endfunction

    function automatic logic [18:0] model_outs(input int k);
        logic t, v, o;
        logic [15:0] d;
        t = 1'b0; v = 1'b0; o = 1'b0; d = 16'h7FFF;
        foreach (trig_starts[i])
            if (k >= trig_starts[i] && k < trig_starts[i] + p_trig) t = 1'b1;
        foreach (m_edge[i]) begin
            if (m_edge[i] == k) begin
                if (m_is_to[i]) o = 1'b1;
                else v = 1'b1;
            end
            if (m_edge[i] <= k) d = m_val[i];
        end
        return {t, v, o, d};
    endfunction

    task automatic push_evt(input int e, input logic [15:0] v, input logic is_to);
        m_edge.push_back(e);
        m_val.push_back(v);
        m_is_to.push_back(is_to);
    endtask

    task automatic build_model(input int n_cyc);
        m_edge.delete(); m_val.delete(); m_is_to.delete(); trig_starts.delete();
        for (int t = 1; t <= n_cyc; t += p_per) begin
            int w1, r, h;
            w1 = t + p_trig + 1;
            r = -1;
            h = 0;
            trig_starts.push_back(t);
            for (int k = w1; k < w1 + p_to; k++)
                if (r < 0 && echo_seen(k)) r = k;
            if (r < 0) begin
                push_evt(w1 + p_to - 1, 16'h7FFF, 1'b1);
            end else begin
                while (h < p_to && echo_seen(r + h)) h++;
                if (h >= p_to) push_evt(r + p_to - 1, 16'h7FFF, 1'b1);
                else if (h / p_cpu > 32766) push_evt(r + h, 16'h7FFE, 1'b0);
                else push_evt(r + h, 16'(h / p_cpu), 1'b0);
            end
        end
    endtask

    task automatic set_params(input int s, input int tr, input int cpu, input int to,
                              input int per);
        sel = s; p_trig = tr; p_cpu = cpu; p_to = to; p_per = per;
        ev_rise.delete();
        ev_len.delete();
    endtask

    task automatic add_echo(input int r, input int l);
        ev_rise.push_back(r);
        ev_len.push_back(l);
    endtask

    task automatic set_echo(input logic v);
        if (sel != 0) echo_b = v;
        else echo_a = v;
    endtask

    // Runs one scenario from reset for n_cyc edges. rst_at > 0 asserts
    // rstn asynchronously in the low phase after that edge and stops.
    task automatic run_scn(input string nm, input int n_cyc, input int rst_at);
        logic [18:0] idle_exp;
        logic [18:0] cur;
        bit stop;
        idle_exp = {3'b000, 16'h7FFF};
        stop = 0;
        build_model(n_cyc);
        obs_valid = 0; obs_to = 0; obs_valid_edge = 0; obs_to_edge = 0;
        obs_trig_q.delete();
        prev_trig = 1'b0;
        obs_dist = 16'h7FFF;
        echo_a = 1'b0;
        echo_b = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check({nm, " reset outs"}, 32'(dut_outs()), 32'(idle_exp));
        check({nm, " reset state"}, 32'((sel != 0) ? st_b : st_a), 32'(IDLE));
        rstn = 1'b1;
        for (int k = 1; k <= n_cyc && !stop; k++) begin
            set_echo(echo_raw(k));
            @(posedge clk);
            @(negedge clk);
            cur = dut_outs();
            check_cyc(nm, k, cur, model_outs(k));
            if (cur[17]) begin obs_valid++; obs_valid_edge = k; end
            if (cur[16]) begin obs_to++; obs_to_edge = k; end
            if (cur[18] && !prev_trig) obs_trig_q.push_back(k);
            prev_trig = cur[18];
            obs_dist = cur[15:0];
            if (k == rst_at) begin
                check({nm, " pre-reset state"}, 32'((sel != 0) ? st_b : st_a), 32'(MEASURE));
                #2 rstn = 1'b0;
                #1 check({nm, " async reset outs"}, 32'(dut_outs()), 32'(idle_exp));
                check({nm, " async reset state"}, 32'((sel != 0) ? st_b : st_a), 32'(IDLE));
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check({nm, " held reset outs"}, 32'(dut_outs()), 32'(idle_exp));
                end
                stop = 1;
            end
        end
    endtask

    initial begin
        // Basic measurement: 50 high cycles -> 5 units
        set_params(0, A_TRIG, A_CPU, A_TO, A_PER);
        add_echo(35, 50);
        run_scn("basic", 520, 0);
        check("basic dist", 32'(obs_dist), 32'd5);
        check("basic valid count", obs_valid, 1);
        check("basic valid edge", obs_valid_edge, 87);
        check("basic timeout count", obs_to, 0);
        check("basic first trig", obs_trig_q[0], 1);
        check("basic second trig", obs_trig_q[1], 501);

        // Short echo: 9 high cycles -> 0 units, still a good reading
        set_params(0, A_TRIG, A_CPU, A_TO, A_PER);
        add_echo(35, 9);
        run_scn("short", 120, 0);
        check("short dist", 32'(obs_dist), 32'd0);
        check("short valid edge", obs_valid_edge, 46);
        check("short timeout count", obs_to, 0);

        // Missing echo: timeout 200 cycles after trig falls
        set_params(0, A_TRIG, A_CPU, A_TO, A_PER);
        run_scn("missing", 300, 0);
        check("missing timeout edge", obs_to_edge, 205);
        check("missing timeout count", obs_to, 1);
        check("missing dist", 32'(obs_dist), 32'h7FFF);
        check("missing valid count", obs_valid, 0);

        // Stuck echo: timeout in MEASURE, next period rises immediately
        set_params(0, A_TRIG, A_CPU, A_TO, A_PER);
        add_echo(100, 100000);
        run_scn("stuck", 720, 0);
        check("stuck timeout count", obs_to, 2);
        check("stuck last timeout edge", obs_to_edge, 705);
        check("stuck valid count", obs_valid, 0);
        check("stuck dist", 32'(obs_dist), 32'h7FFF);
        check("stuck second trig", obs_trig_q[1], 501);

        // Glitches in WAIT_PERIOD, then reset in the middle of MEASURE
        set_params(0, A_TRIG, A_CPU, A_TO, A_PER);
        add_echo(35, 70);
        add_echo(200, 10);
        add_echo(300, 3);
        add_echo(480, 5);
        add_echo(540, 100);
        run_scn("glitch_reset", 700, 580);
        check("glitch dist before reset", 32'(obs_dist), 32'd7);
        check("glitch valid count", obs_valid, 1);
        check("glitch timeout count", obs_to, 0);

        // Saturation: 33000 high cycles at one cycle per unit
        set_params(1, B_TRIG, B_CPU, B_TO, B_PER);
        add_echo(50, 33000);
        run_scn("sat", 33060, 0);
        check("sat dist", 32'(obs_dist), 32'h7FFE);
        check("sat valid edge", obs_valid_edge, 33052);
        check("sat timeout count", obs_to, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
